// File: rtl/zeri_pari_pkg.sv
// Shared types and helpers for the round-robin zero-parity scheduler.
package zeri_pari_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    SHIFT  = 2'd2,
    REPORT = 2'd3
  } sched_state_t;

  localparam logic S_EVEN = 1'b0;
  localparam logic S_ODD  = 1'b1;

  // Scans upward from ptr+1 with wrap over n requesters; returns the first hit one-hot.
  function automatic logic [15:0] rr_pick(input logic [15:0] req, input logic [3:0] ptr,
                                          input int n);
    logic [15:0] g;
    logic        found;
    int          s;
    g     = '0;
    found = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      if (i <= n && !found) begin
        s = (int'(ptr) + i) % n;
        if (req[s[3:0]]) begin
          g[s[3:0]] = 1'b1;
          found     = 1'b1;
        end
      end
    end
    return g;
  endfunction

endpackage

// File: rtl/zeri_pari_core.sv
// Serial even-zeros tracker: toggles on each 0 bit fed while enabled.
module zeri_pari_core
  import zeri_pari_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  input  logic din,
  output logic even
);

  logic st;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st <= S_EVEN;
    end else if (clr) begin
      st <= S_EVEN;
    end else if (en && !din) begin
      st <= ~st;
    end
  end

  assign even = (st == S_EVEN);

endmodule

// File: rtl/zeri_pari_sched.sv
// Round-robin scheduler sharing one serial zero-parity tracker among N_REQ requesters.
//   state  | meaning
//   IDLE   | arbitrate among asserted requests
//   LOAD   | capture granted word, clear tracker
//   SHIFT  | feed WIDTH bits MSB-first into tracker
//   REPORT | one-cycle done with result and id
module zeri_pari_sched
  import zeri_pari_pkg::*;
#(
  parameter  int N_REQ = 4,
  parameter  int WIDTH = 8,
  localparam int ID_W  = $clog2(N_REQ)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*WIDTH-1:0] word_i,
  output logic [N_REQ-1:0]       gnt,
  output logic                   busy,
  output logic                   bit_o,
  output logic                   bit_vld,
  output logic                   done,
  output logic [ID_W-1:0]        done_id,
  output logic                   result
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  sched_state_t     state;
  logic [ID_W-1:0]  ptr;
  logic [ID_W-1:0]  gnt_idx;
  logic [ID_W-1:0]  pick_idx;
  logic [N_REQ-1:0] gnt_nxt;
  logic [WIDTH-1:0] shreg;
  logic [CNT_W-1:0] cnt;
  logic             trk_even;

  always_comb begin
    gnt_nxt  = N_REQ'(rr_pick(16'(req), 4'(ptr), N_REQ));
    pick_idx = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (gnt_nxt[k]) pick_idx = ID_W'(k);
    end
  end

  zeri_pari_core u_core (
    .clk   (clk),
    .reset (reset),
    .clr   (state == LOAD),
    .en    (state == SHIFT),
    .din   (shreg[WIDTH-1]),
    .even  (trk_even)
  );

  assign bit_o = shreg[WIDTH-1];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      gnt     <= '0;
      gnt_idx <= '0;
      busy    <= 1'b0;
      bit_vld <= 1'b0;
      done    <= 1'b0;
      done_id <= '0;
      result  <= 1'b0;
      cnt     <= '0;
      ptr     <= ID_W'(N_REQ - 1);
      shreg   <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (|req) begin
            gnt     <= gnt_nxt;
            gnt_idx <= pick_idx;
            busy    <= 1'b1;
            state   <= LOAD;
          end
        end
        LOAD: begin
          shreg   <= word_i[int'(gnt_idx)*WIDTH +: WIDTH];
          cnt     <= '0;
          bit_vld <= 1'b1;
          state   <= SHIFT;
        end
        SHIFT: begin
          shreg <= {shreg[WIDTH-2:0], 1'b0};
          cnt   <= cnt + CNT_W'(1);
          if (cnt == LAST) begin
            // Tracker updates on this same edge, so fold the final bit in here.
            result  <= trk_even ^ ~shreg[WIDTH-1];
            bit_vld <= 1'b0;
            done    <= 1'b1;
            done_id <= gnt_idx;
            ptr     <= gnt_idx;
            state   <= REPORT;
          end
        end
        REPORT: begin
          gnt   <= '0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/zeri_pari_sched.md
Name: zeri_pari_sched

Overview:
Round-robin scheduler that shares one serial even-zeros parity tracker among N_REQ requesters. Each requester presents a WIDTH-bit word. The block grants one requester, captures its word and shifts it MSB-first through the tracker. It then returns a one-cycle done pulse carrying the result (1 = even number of zeros) and the granted requester's ID. It sits between the requesting blocks and the serial zero-parity datapath.

Parameters:
N_REQ, 4, number of requesters (2..16)
WIDTH, 8, bits per word (2..32)
ID_W, $clog2(N_REQ), width of requester ID (derived, not overridden)

Ports:
clk  in  1  clock; all state updates on rising edge
reset  in  1  asynchronous, active-low reset
req  in  N_REQ  request per requester; level, sampled only in IDLE
word_i  in  N_REQ*WIDTH  packed words; requester k uses bits [k*WIDTH +: WIDTH]
gnt  out  N_REQ  one-hot grant; high from LOAD through REPORT inclusive
busy  out  1  high in any state other than IDLE
bit_o  out  1  bit currently fed to tracker (valid when bit_vld=1)
bit_vld  out  1  high during SHIFT only
done  out  1  one-cycle pulse in REPORT
done_id  out  ID_W  ID of the requester just served; holds until next REPORT
result  out  1  1 = even zero count in the served word; holds until next REPORT

Behaviour:
- Reset (async, reset=0) forces: state=IDLE, gnt=0, busy=0, bit_o=0, bit_vld=0, done=0, done_id=0, result=0, tracker=S_EVEN, bit count=0, RR pointer=N_REQ-1 (so requester 0 has first priority).
- FSM states: IDLE, LOAD, SHIFT, REPORT.
- IDLE: if |req, select the first asserted req scanning from ptr+1 upward with wrap. Register the one-hot grant. Next state is LOAD. If req=0, stay in IDLE.
- LOAD, 1 cycle: capture the granted word into the shift register, set tracker=S_EVEN and cnt=0. Next state is SHIFT.
- SHIFT, exactly WIDTH cycles: bit_o=shreg MSB and bit_vld=1. The tracker toggles on bit 0 and holds on bit 1. Shift left and increment cnt. When cnt==WIDTH-1, the next state is REPORT.
- REPORT, 1 cycle: done=1, result=(tracker==S_EVEN) after all bits, done_id=granted index, ptr=granted index. Next state is IDLE, where gnt drops to 0.
- Latency: req sampled at edge k in IDLE gives gnt high from cycle k+1. done is high in cycle k+WIDTH+2. Minimum spacing between consecutive dones is WIDTH+3 cycles.
- The earliest re-grant is the IDLE cycle right after REPORT. Only req values sampled in IDLE matter.
- Changes to req or word_i after LOAD are ignored. Dropping req mid-transfer does not abort the transfer.
- Simultaneous requests: strict round-robin. The requester just served has lowest priority in the next arbitration.
- A single persistent requester is re-granted every WIDTH+3 cycles.
- Reset asserted mid-transfer aborts immediately to reset values. No done is issued for the aborted word.
- The result width rule is the zero count modulo 2. All-ones gives result=1. All-zeros gives result=1 when WIDTH is even and 0 when WIDTH is odd.

Decomposition:
- Package zeri_pari_pkg holds:
  - typedef enum sched_state_t {IDLE, LOAD, SHIFT, REPORT};
  - parity state constants S_EVEN=1'b0 and S_ODD=1'b1;
  - function rr_pick(req, ptr), returning a one-hot vector.
- Sub-module zeri_pari_core is a clocked serial tracker. Ports: clk, reset, clr, en, din, even. It holds the state register with the same async active-low reset. The scheduler instantiates one zeri_pari_core and keeps the arbiter, counter and shift register locally.

Test Plan:
- Reset then req=4'b0001 with word0=8'hA5 (4 zeros): gnt=0001 from k+1, bit_o sequence 1,0,1,0,0,1,0,1, done at k+10 with result=1, done_id=0.
- req=4'b0100, word2=8'h07 (5 zeros): done_id=2, result=0. Also 8'hFF → result=1 and 8'h00 → result=1.
- req=4'b1111 held: grants in order 0,1,2,3,0, each done exactly 11 cycles apart. gnt is always one-hot or zero.
- req0 dropped and word0 changed during SHIFT: transfer completes on the captured word with the correct result. Changes to req0 or word0 after LOAD have no effect.
- Reset pulsed during SHIFT of requester 1: all outputs return to reset values at once and no done is issued. After release, req=4'b0011 grants requester 0 first.
- Idle stability: req=0 for 50 cycles gives busy=0, done=0, and done_id/result holding their previous values.
